// File: rtl/seg_bus_pkg.sv
// rtl/seg_bus_pkg.sv - shared seven-segment code table and pattern decoder
package seg_bus_pkg;

  localparam logic [7:0] SEL_BLANK = 8'hFF;

  // Active-high a..g,dp patterns; entry i is the pattern for code i.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h00, 8'h1E, 8'h96, 8'h46, 8'h32, 8'h1A, 8'hF6, 8'hFE,
    8'hE4, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };

  typedef struct packed {
    logic       legal;
    logic [3:0] code;
  } seg_decode_t;

  function automatic seg_decode_t seg_decode(input logic [7:0] pat);
    seg_decode_t r;
    r.legal = 1'b0;
    r.code  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (SEG_TABLE[i] == pat) begin
        r.legal = 1'b1;
        r.code  = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_bus_sync_filter.sv
// rtl/seg_bus_sync_filter.sv - two-flop synchroniser and stability filter for the display bus
module seg_bus_sync_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_i,
  output logic [15:0] value_o,
  output logic        accept_o
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [15:0]   sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          same;

  assign same = (sync2_q == prev_q);

  // Saturating counter: one accept per stable run, on the step into STABLE_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign accept_o = same && (cnt_q == CW'(STABLE_CYCLES - 1));
  assign value_o  = sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 16'hFFFF;
      sync2_q <= 16'hFFFF;
      prev_q  <= 16'hFFFF;
      cnt_q   <= '0;
    end else begin
      sync1_q <= bus_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_bus_monitor.sv
// rtl/seg_bus_monitor.sv - recovers digit position/code from the muxed segment bus and checks roaming
import seg_bus_pkg::*;

module seg_bus_monitor #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sel_n,
  input  logic [7:0] seg_n,
  input  logic       clr,
  output logic [2:0] pos,
  output logic [3:0] code,
  output logic       upd,
  output logic       step,
  output logic       dir_up,
  output logic       err_sel,
  output logic       err_seg,
  output logic       err_seq
);

  logic [15:0] acc_val;
  logic        acc;

  seg_bus_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .bus_i    ({sel_n, seg_n}),
    .value_o  (acc_val),
    .accept_o (acc)
  );

  logic [7:0]  acc_sel_n;
  logic [3:0]  zeros;
  logic [2:0]  k;
  seg_decode_t dec;

  assign acc_sel_n = acc_val[15:8];
  assign dec       = seg_decode(~acc_val[7:0]);

  always_comb begin
    zeros = 4'd0;
    k     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!acc_sel_n[i]) begin
        zeros = zeros + 1'b1;
        k     = 3'(i);
      end
    end
  end

  logic [2:0] pos_q, pos_d;
  logic [3:0] code_q, code_d;
  logic       dir_q, dir_d, have_prev_q, have_prev_d;
  logic       upd_q, upd_d, step_q, step_d;
  logic       err_sel_q, err_sel_d, err_seg_q, err_seg_d, err_seq_q, err_seq_d;
  logic       seq_bad;

  always_comb begin
    pos_d       = pos_q;
    code_d      = code_q;
    dir_d       = dir_q;
    have_prev_d = have_prev_q;
    upd_d       = 1'b0;
    step_d      = 1'b0;
    err_sel_d   = 1'b0;
    err_seg_d   = 1'b0;
    seq_bad     = 1'b0;
    if (acc && acc_sel_n != SEL_BLANK) begin
      if (zeros > 4'd1) begin
        err_sel_d = 1'b1;
      end else if (!dec.legal) begin
        err_seg_d = 1'b1;
      end else begin
        upd_d       = 1'b1;
        pos_d       = k;
        code_d      = dec.code;
        have_prev_d = 1'b1;
        // Up roam walks toward lower indices; only a wrap may change the code.
        if (have_prev_q) begin
          if (k == pos_q - 3'd1) begin
            step_d  = 1'b1;
            dir_d   = 1'b1;
            seq_bad = (pos_q == 3'd0) ? (dec.code != code_q + 4'd1) : (dec.code != code_q);
          end else if (k == pos_q + 3'd1) begin
            step_d  = 1'b1;
            dir_d   = 1'b0;
            seq_bad = (pos_q == 3'd7) ? (dec.code != code_q - 4'd1) : (dec.code != code_q);
          end else if (k != pos_q) begin
            seq_bad = 1'b1;
          end
        end
      end
    end
    err_seq_d = seq_bad ? 1'b1 : (clr ? 1'b0 : err_seq_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q       <= 3'd0;
      code_q      <= 4'd0;
      dir_q       <= 1'b0;
      have_prev_q <= 1'b0;
      upd_q       <= 1'b0;
      step_q      <= 1'b0;
      err_sel_q   <= 1'b0;
      err_seg_q   <= 1'b0;
      err_seq_q   <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      code_q      <= code_d;
      dir_q       <= dir_d;
      have_prev_q <= have_prev_d;
      upd_q       <= upd_d;
      step_q      <= step_d;
      err_sel_q   <= err_sel_d;
      err_seg_q   <= err_seg_d;
      err_seq_q   <= err_seq_d;
    end
  end

  assign pos     = pos_q;
  assign code    = code_q;
  assign upd     = upd_q;
  assign step    = step_q;
  assign dir_up  = dir_q;
  assign err_sel = err_sel_q;
  assign err_seg = err_seg_q;
  assign err_seq = err_seq_q;

endmodule
